// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer around an 8x8 MAC: start/len job, valid/ready operand stream, valid/ready result.
// Optional saturation: define MAC_DOT_SAT_EN to clamp on overflow; the default build wraps.
module mac_dot_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 22,
   parameter int LEN_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  result,
   output logic              ovf
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                ovf_q, ovf_d;

   logic [2*DATA_W-1:0] prod_s;
   logic [ACC_W:0]      sum_s;
   logic                beat_s;
   logic                last_s;

   assign prod_s = a * b;
   // One extra bit on the sum exposes the carry out of the accumulator.
   assign sum_s  = {1'b0, acc_q} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod_s};
   assign beat_s = in_valid & (state_q == ST_ACCUM);
   assign last_s = (cnt_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d = {ACC_W{1'b0}};
               cnt_d = {LEN_W{1'b0}};
               ovf_d = 1'b0;
               len_d = len;
               if (len != {LEN_W{1'b0}}) begin
                  state_d = ST_ACCUM;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (beat_s) begin
               cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
               if (sum_s[ACC_W]) begin
                  ovf_d = 1'b1;
               end else begin
                  ovf_d = ovf_q;
               end
`ifdef MAC_DOT_SAT_EN
               if (sum_s[ACC_W]) begin
                  acc_d = {ACC_W{1'b1}};
               end else begin
                  acc_d = sum_s[ACC_W-1:0];
               end
`else
               acc_d = sum_s[ACC_W-1:0];
`endif
               if (last_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         acc_q   <= {ACC_W{1'b0}};
         cnt_q   <= {LEN_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_DONE);
   assign result    = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed self-checking bench for mac_dot_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_mac_dot_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [6:0]  len;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] result;
   logic        ovf;

   int tests_run;
   int tests_failed;

   mac_dot_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_job(input logic [6:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
      len   = 7'd0;
   endtask

   task automatic beat(input logic [7:0] av, input logic [7:0] bv);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL beat_ready_timeout got=%b want=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic accept;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1;
      tests_run++;
      if ({busy, in_ready, out_valid, ovf} !== 4'b0000 || result !== 22'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs got busy/rdy/ov/ovf=%b result=%0d want 0000 0",
                  {busy, in_ready, out_valid, ovf}, result);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release_idle got busy=%b want=0", busy);
      end
   endtask

   task automatic test_basic;
      start_job(7'd3);
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_accum_entry got busy=%b rdy=%b want 1 1", busy, in_ready);
      end
      beat(8'd134, 8'd120);
      beat(8'd10, 8'd10);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_early_valid got=%b want=0", out_valid);
      end
      beat(8'd101, 8'd21);
      tests_run++;
      if (out_valid !== 1'b1 || result !== 22'd18301 || ovf !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_result got ov=%b result=%0d ovf=%b rdy=%b want 1 18301 0 0",
                  out_valid, result, ovf, in_ready);
      end
      accept();
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_return_idle got busy=%b ov=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_stall;
      start_job(7'd3);
      beat(8'd134, 8'd120);
      repeat (2) @(negedge clk);
      beat(8'd10, 8'd10);
      repeat (2) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_hold got ov=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      beat(8'd101, 8'd21);
      // Junk operands offered while the result is back-pressured must not be absorbed.
      in_valid = 1'b1;
      a        = 8'd255;
      b        = 8'd255;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (out_valid !== 1'b1 || result !== 22'd18301 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_done_cycle%0d got ov=%b result=%0d rdy=%b want 1 18301 0",
                     i, out_valid, result, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      accept();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_return_idle got busy=%b want=0", busy);
      end
   endtask

   task automatic test_len0_and_ignore;
      start_job(7'd0);
      tests_run++;
      if (out_valid !== 1'b1 || result !== 22'd0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL len0_result got ov=%b result=%0d rdy=%b ovf=%b want 1 0 0 0",
                  out_valid, result, in_ready, ovf);
      end
      start_job(7'd5);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL len0_start_in_done got ov=%b rdy=%b want 1 0", out_valid, in_ready);
      end
      accept();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL len0_idle got busy=%b want=0", busy);
      end
      start_job(7'd2);
      beat(8'd1, 8'd2);
      start_job(7'd5);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_in_accum got rdy=%b ov=%b want 1 0", in_ready, out_valid);
      end
      beat(8'd3, 8'd4);
      tests_run++;
      if (out_valid !== 1'b1 || result !== 22'd14) begin
         tests_failed++;
         $display("FAIL start_in_accum_len got ov=%b result=%0d want 1 14", out_valid, result);
      end
      accept();
   endtask

   task automatic test_reset_mid_job;
      start_job(7'd3);
      beat(8'd50, 8'd50);
      beat(8'd60, 8'd60);
      rst = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 22'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_job got busy=%b ov=%b rdy=%b result=%0d want 0 0 0 0",
                  busy, out_valid, in_ready, result);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start_job(7'd2);
      beat(8'd20, 8'd20);
      beat(8'd20, 8'd20);
      tests_run++;
      if (out_valid !== 1'b1 || result !== 22'd800) begin
         tests_failed++;
         $display("FAIL reset_then_job got ov=%b result=%0d want 1 800", out_valid, result);
      end
      accept();
   endtask

   task automatic test_overflow;
      logic [21:0] exp_res;
`ifdef MAC_DOT_SAT_EN
      exp_res = 22'd4194303;
`else
      exp_res = 22'd4063871;
`endif
      start_job(7'd127);
      for (int i = 0; i < 127; i++) begin
         beat(8'd255, 8'd255);
         // 64 full-scale products fit exactly; the 65th carries out.
         if (i == 63) begin
            tests_run++;
            if (ovf !== 1'b0) begin
               tests_failed++;
               $display("FAIL ovf_after_64 got=%b want=0", ovf);
            end
         end else if (i == 64) begin
            tests_run++;
            if (ovf !== 1'b1) begin
               tests_failed++;
               $display("FAIL ovf_after_65 got=%b want=1", ovf);
            end
         end
      end
      tests_run++;
      if (out_valid !== 1'b1 || result !== exp_res || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL overflow_result got ov=%b result=%0d ovf=%b want 1 %0d 1",
                  out_valid, result, ovf, exp_res);
      end
      accept();
   endtask

   task automatic test_back_to_back;
      start_job(7'd1);
      beat(8'd3, 8'd4);
      tests_run++;
      if (out_valid !== 1'b1 || result !== 22'd12 || ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_first got ov=%b result=%0d ovf=%b want 1 12 0", out_valid, result, ovf);
      end
      accept();
      start_job(7'd1);
      beat(8'd5, 8'd6);
      tests_run++;
      if (out_valid !== 1'b1 || result !== 22'd30) begin
         tests_failed++;
         $display("FAIL b2b_second got ov=%b result=%0d want 1 30", out_valid, result);
      end
      accept();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      start        = 1'b0;
      len          = 7'd0;
      in_valid     = 1'b0;
      a            = 8'd0;
      b            = 8'd0;
      out_ready    = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_len0_and_ignore();
      test_reset_mid_job();
      test_overflow();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
